// File: rtl/fft_output_packer.sv
// Collects a frame of serial FFT result samples and returns it as wide host lines.
// Optional macro FFT_OUT_BITREV_EN stores a bit-reversed input stream in natural order.
module fft_output_packer #(
  parameter int SAMPLE_W    = 16,
  parameter int LINE_W      = 512,
  parameter int NUM_SAMPLES = 2048
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  input  logic [SAMPLE_W-1:0]                         in_data,
  output logic                                        in_ready,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [LINE_W-1:0]                           out_data,
  output logic [$clog2(NUM_SAMPLES*SAMPLE_W/LINE_W)-1:0] out_index,
  output logic                                        out_last,
  output logic                                        frame_done
);

  localparam int LANES      = LINE_W / SAMPLE_W;
  localparam int NUM_LINES  = NUM_SAMPLES / LANES;
  localparam int CNT_W      = $clog2(NUM_SAMPLES);
  localparam int LINE_CNT_W = $clog2(NUM_LINES);
  localparam int LANE_W     = $clog2(LANES);

  typedef enum logic [1:0] {FILL, LOAD, DRAIN} state_t;

  state_t                state, next_state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      wr_addr;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic [LINE_W-1:0]     load_line;
  logic [SAMPLE_W-1:0]   mem [NUM_SAMPLES];
  logic                  accept_in;
  logic                  accept_out;
  logic                  last_sample;
  logic                  last_line;

  assign accept_in   = in_valid && in_ready;
  assign accept_out  = out_valid && out_ready;
  assign last_sample = (cnt == CNT_W'(NUM_SAMPLES - 1));
  assign last_line   = (line_cnt == LINE_CNT_W'(NUM_LINES - 1));

`ifdef FFT_OUT_BITREV_EN
  always_comb begin
    wr_addr = '0;
    for (int b = 0; b < CNT_W; b++) begin
      wr_addr[b] = cnt[CNT_W-1-b];
    end
  end
`else
  assign wr_addr = cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (accept_in && last_sample) next_state = LOAD;
      LOAD:    next_state = DRAIN;
      DRAIN:   if (out_ready) next_state = last_line ? FILL : LOAD;
      default: next_state = FILL;
    endcase
  end

  // in_ready is gated by rst so the core never sees a handshake while reset is held.
  always_comb begin
    in_ready  = (state == FILL) && !rst;
    out_valid = (state == DRAIN);
    out_last  = out_valid && (out_index == LINE_CNT_W'(NUM_LINES - 1));
  end

  always_comb begin
    load_line = '0;
    for (int j = 0; j < LANES; j++) begin
      load_line[j*SAMPLE_W +: SAMPLE_W] = mem[{line_cnt, LANE_W'(j)}];
    end
  end

  // Frame buffer is deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (accept_in) begin
      mem[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      line_cnt   <= '0;
      out_data   <= '0;
      out_index  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept_out && last_line;
      if (accept_in) begin
        cnt <= cnt + 1'b1;
      end
      if (state == LOAD) begin
        out_data  <= load_line;
        out_index <= line_cnt;
      end
      if (accept_out) begin
        line_cnt <= line_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_output_packer.sv
// Randomised scoreboard bench for fft_output_packer: frames are modelled as sample
// lists, turned into expected lines on the 2048th accept, and popped by a monitor.
module tb_fft_output_packer;

  localparam int NS    = 2048;
  localparam int LANES = 32;
  localparam int NL    = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic [5:0]   out_index;
  logic         out_last;
  logic         frame_done;

  typedef struct {
    logic [511:0] data;
    int           index;
    bit           last;
  } line_t;

  line_t       sb_q[$];
  logic [15:0] frame_q[$];
  int checks     = 0;
  int errors     = 0;
  int ready_mode = 0;
  int hold       = 0;
  int done_count = 0;

  fft_output_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic finishRun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Where the k-th accepted sample of a frame lands in the frame buffer.
  function automatic int storeAddr(input int k);
`ifdef FFT_OUT_BITREV_EN
    int r = 0;
    for (int b = 0; b < 11; b++) if ((k >> b) & 1) r += (1 << (10 - b));
    return r;
`else
    return k;
`endif
  endfunction

  task automatic pushFrame();
    logic [15:0] store [NS];
    line_t e;
    for (int i = 0; i < NS; i++) store[storeAddr(i)] = frame_q[i];
    for (int l = 0; l < NL; l++) begin
      e.data = '0;
      for (int j = 0; j < LANES; j++) e.data[16*j +: 16] = store[LANES*l + j];
      e.index = l;
      e.last  = (l == NL - 1);
      sb_q.push_back(e);
    end
    frame_q.delete();
  endtask

  task automatic applyStimulus(input logic [15:0] d);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 5000) begin
        checks++;
        errors++;
        $display("[TB] FAIL in_ready_timeout waited %0d cycles", waited);
        finishRun();
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    frame_q.push_back(d);
    if (frame_q.size() == NS) pushFrame();
  endtask

  task automatic idleCycle();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input int cycles);
    rst      = 1'b1;
    in_valid = 1'b0;
    frame_q.delete();
    repeat (cycles) begin
      @(negedge clk);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_index", out_index, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_reset", in_ready, 1);
    checkOutput("idle_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  // out_ready driver: always ready, random, or a 10-cycle stall on line 5.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && out_index == 6'd5 && hold < 10) begin
            out_ready = 1'b0;
            hold++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: pops expected lines on each output handshake and checks protocol timing.
  initial begin
    logic [511:0] prev_data;
    logic [5:0]   prev_index;
    bit           prev_valid = 0;
    bit           prev_acc   = 0;
    bit           expect_done = 0;
    bit           wait_next  = 0;
    int           gap        = 0;
    line_t        e;
    prev_data  = '0;
    prev_index = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid  = 0;
        prev_acc    = 0;
        expect_done = 0;
        wait_next   = 0;
      end else begin
        checkOutput("frame_done", frame_done, expect_done);
        if (frame_done) begin
          done_count++;
          checkOutput("in_ready_at_done", in_ready, 1);
        end
        expect_done = 0;
        if (wait_next) begin
          gap++;
          if (out_valid) begin
            checkOutput("line_gap", gap, 2);
            wait_next = 0;
          end
        end
        if (prev_valid && !prev_acc) begin
          checkOutput("valid_held", out_valid, 1);
          if (out_valid) begin
            checkOutput("data_stable", out_data, prev_data);
            checkOutput("index_stable", out_index, prev_index);
          end
        end
        if (!out_valid) checkOutput("out_last_idle", out_last, 0);
        if (out_valid) begin
          checkOutput("in_ready_in_drain", in_ready, 0);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_line index %0d with nothing expected", out_index);
          end else if (out_ready) begin
            e = sb_q.pop_front();
            checkOutput("out_data", out_data, e.data);
            checkOutput("out_index", out_index, e.index);
            checkOutput("out_last", out_last, e.last);
            if (e.last) expect_done = 1;
            else begin
              wait_next = 1;
              gap = 0;
            end
          end
        end
        prev_valid = out_valid;
        prev_acc   = out_valid && out_ready;
        prev_data  = out_data;
        prev_index = out_index;
      end
    end
  end

  initial begin
    int waited;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    applyReset(2);
    $display("[TB] frame A: ramp, no gaps, always ready");
    ready_mode = 0;
    for (int k = 0; k < NS; k++) applyStimulus(16'(k));
    $display("[TB] frame B: random data, alternating gaps, stall on line 5");
    ready_mode = 2;
    for (int k = 0; k < NS; k++) begin
      applyStimulus(16'($urandom));
      if (k % 2 == 0) idleCycle();
    end
    $display("[TB] frame C: random data, random gaps, random ready");
    ready_mode = 1;
    for (int k = 0; k < NS; k++) begin
      if ($urandom_range(0, 3) == 0) idleCycle();
      applyStimulus(16'($urandom));
    end
    $display("[TB] partial frame then reset, then frame D: ramp + 100");
    ready_mode = 0;
    for (int k = 0; k < 700; k++) applyStimulus(16'($urandom));
    @(posedge clk);
    #1;
    applyReset(2);
    done_count = 3;
    for (int k = 0; k < NS; k++) applyStimulus(16'(k + 100));
    waited = 0;
    while (sb_q.size() != 0 && waited < 5000) begin
      @(posedge clk);
      waited++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout %0d lines outstanding", sb_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput("frame_done_count", done_count, 4);
    finishRun();
  end

endmodule
